async_d_trigger: RTL and testbench

ASYNC_D_TRIGGER -- requirements
Module: async_d_trigger

---
 rtl/async_d_trigger.sv | 48 ++++
 tb/tb_async_d_trigger.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/async_d_trigger.sv
// D flip-flop of WIDTH bits with asynchronous active-high reset to RST_VAL.
// Define ASYNC_D_TRIGGER_ASSERT_EN to add simulation-only checks; they do not change the logic.
module async_d_trigger #(
  parameter int                 WIDTH   = 1,
  parameter logic [WIDTH-1:0]   RST_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] q_q;

  always_comb begin
    q_d = d_i;
  end

  // Reset is in the sensitivity list, so it takes effect without a clock edge
  // and wins over a coincident rising clock edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      q_q <= RST_VAL;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

`ifdef ASYNC_D_TRIGGER_ASSERT_EN
  generate
    if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
      $error("async_d_trigger: WIDTH %0d outside 1..64", WIDTH);
    end
  endgenerate

  // Reset must hold q_o at RST_VAL; checked away from the capture edge.
  a_rst_holds: assert property (@(negedge clk_i) rst_i |-> (q_o == RST_VAL))
    else $error("async_d_trigger: q_o not RST_VAL while rst_i high");

  a_capture: assert property (@(posedge clk_i) disable iff (rst_i)
                              !rst_i |=> (q_o == $past(d_i)))
    else $error("async_d_trigger: q_o does not match previous-edge d_i");
`endif

endmodule

// File: tb/tb_async_d_trigger.sv
// Scoreboard bench for async_d_trigger: 1-bit default instance and an 8-bit instance with RST_VAL 8'hA5.
module tb_async_d_trigger;

  logic       clk;
  logic       rst1;
  logic [0:0] d1;
  logic [0:0] q1;
  logic       rst8;
  logic [7:0] d8;
  logic [7:0] q8;

  typedef struct {
    int         sel;
    logic [7:0] exp;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  event chk_ev;
  int   checks = 0;
  int   errors = 0;

  async_d_trigger #(.WIDTH(1), .RST_VAL(1'b0)) dut1 (
    .clk_i (clk),
    .rst_i (rst1),
    .d_i   (d1),
    .q_o   (q1)
  );

  async_d_trigger #(.WIDTH(8), .RST_VAL(8'hA5)) dut8 (
    .clk_i (clk),
    .rst_i (rst8),
    .d_i   (d8),
    .q_o   (q8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic expect_q(input int sel, input logic [7:0] exp, input string name);
    exp_t e;
    e.sel  = sel;
    e.exp  = exp;
    e.name = name;
    exp_q.push_back(e);
    -> chk_ev;
  endtask

  // Monitor: drains every pending expectation at the moment it is signalled.
  initial begin
    exp_t       e;
    logic [7:0] act;
    forever begin
      @(chk_ev);
      while (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        act = (e.sel == 0) ? {7'b0, q1} : q8;
        checks++;
        if (act !== e.exp) begin
          errors++;
          $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
        end else begin
          $display("ok   %s: q=%h", e.name, act);
        end
      end
    end
  end

  initial begin
    rst1 = 1'b1; d1 = 1'b1;
    rst8 = 1'b1; d8 = 8'h3C;

    // Edge at 5 ns with reset high: reset dominates.
    @(posedge clk); #1;
    expect_q(0, 8'h00, "rst_dominance");
    expect_q(1, 8'hA5, "w8_rst_val");

    rst1 = 1'b0; d1 = 1'b1;
    rst8 = 1'b0;
    @(posedge clk); #1;
    expect_q(0, 8'h01, "capture_1");
    expect_q(1, 8'h3C, "w8_capture_3c");

    // d changes between edges must not reach q.
    d1 = 1'b0; d8 = 8'h00;
    #3;
    expect_q(0, 8'h01, "hold_between_edges");
    expect_q(1, 8'h3C, "w8_hold_between_edges");

    @(posedge clk); #1;
    expect_q(0, 8'h00, "capture_0");

    d1 = 1'b1; d8 = 8'h3C;
    @(posedge clk); #1;
    expect_q(0, 8'h01, "capture_1_again");
    expect_q(1, 8'h3C, "w8_recapture_3c");

    // Mid-cycle asynchronous reset, no clock edge in between.
    rst1 = 1'b1; rst8 = 1'b1;
    #1;
    expect_q(0, 8'h00, "async_midcycle_rst");
    expect_q(1, 8'hA5, "w8_async_rst");

    for (int i = 0; i < 3; i++) begin
      d1 = ~d1; d8 = ~d8;
      @(posedge clk); #1;
      expect_q(0, 8'h00, $sformatf("rst_hold_edge%0d", i));
      expect_q(1, 8'hA5, $sformatf("w8_rst_hold_edge%0d", i));
    end

    // Release mid-cycle: q stays at reset value until the next edge.
    #2;
    rst1 = 1'b0; d1 = 1'b1;
    rst8 = 1'b0; d8 = 8'hFF;
    #1;
    expect_q(0, 8'h00, "release_wait");
    expect_q(1, 8'hA5, "w8_release_wait");

    @(posedge clk); #1;
    expect_q(0, 8'h01, "release_capture");
    expect_q(1, 8'hFF, "w8_capture_ff");

    // Per-bit independence patterns.
    d8 = 8'h5A;
    @(posedge clk); #1;
    expect_q(1, 8'h5A, "w8_capture_5a");
    d8 = 8'h81;
    @(posedge clk); #1;
    expect_q(1, 8'h81, "w8_capture_81");

    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
